// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control types: FSM state encoding, default memory timeout,
// and the bundle of pipeline-register/PC control bits with its canned values.
package pipeline_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam int DEFAULT_MEM_TIMEOUT = 256;

  typedef struct packed {
    logic pc_en;
    logic pc_sel_target;
    logic fd_en;
    logic fd_flush;
    logic ex_en;
    logic ex_bubble;
    logic mem_en;
  } ctrl_t;

  localparam ctrl_t CTRL_NORMAL = '{
    pc_en: 1'b1, pc_sel_target: 1'b0, fd_en: 1'b1, fd_flush: 1'b0,
    ex_en: 1'b1, ex_bubble: 1'b0, mem_en: 1'b1
  };

  localparam ctrl_t CTRL_FREEZE = '{
    pc_en: 1'b0, pc_sel_target: 1'b0, fd_en: 1'b0, fd_flush: 1'b0,
    ex_en: 1'b0, ex_bubble: 1'b0, mem_en: 1'b0
  };

  localparam ctrl_t CTRL_BRANCH = '{
    pc_en: 1'b1, pc_sel_target: 1'b1, fd_en: 1'b1, fd_flush: 1'b1,
    ex_en: 1'b1, ex_bubble: 1'b1, mem_en: 1'b1
  };

  // Load-use: hold PC and IF/ID, inject a bubble into ID/EX, let EX/MEM drain.
  localparam ctrl_t CTRL_LOADUSE = '{
    pc_en: 1'b0, pc_sel_target: 1'b0, fd_en: 1'b0, fd_flush: 1'b0,
    ex_en: 1'b1, ex_bubble: 1'b1, mem_en: 1'b1
  };

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;
  logic         w_full;

  assign w_full = &r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && !w_full) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control: prioritises memory freeze, branch redirect and load-use
// stall; tracks data-memory waits with a timeout watchdog and perf counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int TO_W        = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hz_stall,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             pc_sel_target,
  output logic             fd_en,
  output logic             fd_flush,
  output logic             ex_en,
  output logic             ex_bubble,
  output logic             mem_en,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  state_e          r_state;
  state_e          w_state_next;
  logic [TO_W-1:0] r_wait_cnt;
  logic [TO_W-1:0] w_wait_inc;
  logic            r_mem_err;
  logic            w_freeze;
  logic            w_branch_fire;
  ctrl_t           w_ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:      if (mem_req && !mem_ready) w_state_next = MEM_WAIT;
      MEM_WAIT: if (mem_ready)             w_state_next = RUN;
      default:  w_state_next = RUN;
    endcase
  end

  assign w_freeze = ((r_state == RUN) && mem_req && !mem_ready) ||
                    ((r_state == MEM_WAIT) && !mem_ready);

  always_comb begin
    w_ctrl        = CTRL_NORMAL;
    w_branch_fire = 1'b0;
    if (rst) begin
      w_ctrl = CTRL_NORMAL;
    end else if (w_freeze) begin
      w_ctrl = CTRL_FREEZE;
    end else if (ex_branch_taken) begin
      w_ctrl        = CTRL_BRANCH;
      w_branch_fire = 1'b1;
    end else if (hz_stall) begin
      w_ctrl = CTRL_LOADUSE;
    end
  end

  assign pc_en         = w_ctrl.pc_en;
  assign pc_sel_target = w_ctrl.pc_sel_target;
  assign fd_en         = w_ctrl.fd_en;
  assign fd_flush      = w_ctrl.fd_flush;
  assign ex_en         = w_ctrl.ex_en;
  assign ex_bubble     = w_ctrl.ex_bubble;
  assign mem_en        = w_ctrl.mem_en;

  // Count of MEM_WAIT cycles including the current one, saturating at the limit.
  assign w_wait_inc = (r_wait_cnt == TO_LIMIT) ? r_wait_cnt : r_wait_cnt + TO_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      if (w_state_next == RUN) begin
        r_wait_cnt <= '0;
      end else if (r_state == MEM_WAIT) begin
        r_wait_cnt <= w_wait_inc;
      end
      if ((r_state == MEM_WAIT) && (w_wait_inc == TO_LIMIT)) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  assign mem_err = r_mem_err;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!w_ctrl.pc_en),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_branch_fire),
    .count (flush_count)
  );

endmodule
